// File: rtl/descrambler.sv
// descrambler
//   Receive-side DisplayPort descrambler. Two 8b/10b-decoded symbols arrive
//   per cycle (byte 0 is the earlier one). Data bytes are XORed with the
//   x^16+x^5+x^4+x^3+1 keystream, Scrambler Reset (SR) symbols are rewritten
//   to Blanking Start (BS), and SR placement against the 512-BS period is
//   tracked to report lock and misalignment.
//
// Ports
//   clk      link symbol clock
//   rstn     asynchronous active-low reset
//   indata   scrambled symbols, [7:0] byte 0, [15:8] byte 1
//   inisk    K-flag per byte
//   outdata  descrambled symbols (SR replaced by BS), 1-cycle latency
//   outisk   delayed copy of inisk
//   locked   SR alignment established (registered from the FSM state)
//   err      one-cycle pulse, aligned with the offending symbol on outdata
module descrambler #(
    parameter int MISS_MAX = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] indata,
    input  logic [1:0]  inisk,
    output logic [15:0] outdata,
    output logic [1:0]  outisk,
    output logic        locked,
    output logic        err
);

    localparam logic [7:0]  SYM_BS   = 8'hBC;
    localparam logic [7:0]  SYM_SR   = 8'h1C;
    localparam logic [15:0] SEED     = 16'hFFFF;
    localparam logic [2:0]  MISS_LIM = 3'(MISS_MAX);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [8:0]  slot, slot_nxt;
    logic [2:0]  miss, miss_nxt;
    logic        err_nxt;

    logic [7:0]  b0, b1, key0, key1, ob0, ob1;
    logic [15:0] s8, mid, s16;
    logic        sr0, sr1, bs0, bs1, sr_any, blk, bad;

    // Run the LFSR for one byte. Returns {state after 8 bits, key byte},
    // first keystream bit in key bit 0.
    function automatic logic [23:0] adv8(input logic [15:0] s);
        logic [15:0] st;
        logic [7:0]  key;
        st  = s;
        key = '0;
        for (int i = 0; i < 8; i++) begin
            key[i] = st[15];
            st     = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
        end
        return {st, key};
    endfunction

    assign b0 = indata[7:0];
    assign b1 = indata[15:8];

    assign sr0    = inisk[0] && (b0 == SYM_SR);
    assign sr1    = inisk[1] && (b1 == SYM_SR);
    assign bs0    = inisk[0] && (b0 == SYM_BS);
    assign bs1    = inisk[1] && (b1 == SYM_BS);
    assign sr_any = sr0 | sr1;
    assign blk    = sr_any | bs0 | bs1;

    // An SR in byte 0 restarts the keystream for byte 1 in the same cycle;
    // an SR in byte 1 restarts it for the following cycle and wins if both
    // bytes carry SR.
    assign {s8, key0} = adv8(lfsr);
    assign mid        = sr0 ? SEED : s8;
    assign {s16, key1} = adv8(mid);
    assign lfsr_nxt   = sr1 ? SEED : s16;

    assign ob0 = inisk[0] ? (sr0 ? SYM_BS : b0) : (b0 ^ key0);
    assign ob1 = inisk[1] ? (sr1 ? SYM_BS : b1) : (b1 ^ key1);

    // A BS/SR cycle is misplaced when SR shows up away from slot 0 or when
    // slot 0 passes without an SR.
    assign bad = sr_any ? (slot != 9'd0) : (slot == 9'd0);

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        miss_nxt  = miss;
        err_nxt   = 1'b0;
        if (blk) begin
            slot_nxt = sr_any ? 9'd1 : slot + 9'd1;
            if (state == HUNT) begin
                if (sr_any) begin
                    state_nxt = LOCKED;
                    miss_nxt  = 3'd0;
                end
            end else begin
                if (bad) begin
                    err_nxt = 1'b1;
                    if (miss + 3'd1 == MISS_LIM) begin
                        state_nxt = HUNT;
                        miss_nxt  = 3'd0;
                    end else begin
                        miss_nxt = miss + 3'd1;
                    end
                end else if (sr_any) begin
                    miss_nxt = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= HUNT;
            lfsr    <= SEED;
            slot    <= 9'd0;
            miss    <= 3'd0;
            outdata <= 16'h0000;
            outisk  <= 2'b00;
            locked  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            lfsr    <= lfsr_nxt;
            slot    <= slot_nxt;
            miss    <= miss_nxt;
            outdata <= {ob1, ob0};
            outisk  <= inisk;
            locked  <= (state == LOCKED);
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_descrambler.sv
module tb_descrambler;

    localparam int MISS_MAX = 2;
    localparam int KS_LEN   = 65535;

    logic        clk;
    logic        rstn;
    logic [15:0] indata;
    logic [1:0]  inisk;
    logic [15:0] outdata;
    logic [1:0]  outisk;
    logic        locked;
    logic        err;

    descrambler #(.MISS_MAX(MISS_MAX)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .indata (indata),
        .inisk  (inisk),
        .outdata(outdata),
        .outisk (outisk),
        .locked (locked),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  isk;
        logic        err;
        logic        lock;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: keystream as a byte table, a read pointer into it,
    // and the alignment status kept as plain integers.
    bit         kb[KS_LEN*8];
    logic [7:0] ks[KS_LEN];
    int         ptr;
    bit         m_lock;
    int         m_slot;
    int         m_miss;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Keystream bits obey a[m] = a[m-16]^a[m-13]^a[m-12]^a[m-11] for this
    // polynomial; the first 16 bits are the documented opening bytes FF 17.
    task automatic build_keystream();
        logic [15:0] head;
        logic [7:0]  by;
        head = 16'h17FF;
        for (int i = 0; i < 16; i++) kb[i] = head[i];
        for (int m = 16; m < KS_LEN*8; m++)
            kb[m] = kb[m-16] ^ kb[m-13] ^ kb[m-12] ^ kb[m-11];
        for (int i = 0; i < KS_LEN; i++) begin
            for (int j = 0; j < 8; j++) by[j] = kb[8*i+j];
            ks[i] = by;
        end
    endtask

    task automatic model_reset();
        ptr    = 0;
        m_lock = 1'b0;
        m_slot = 0;
        m_miss = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [7:0] d0, input logic k0,
                              input logic [7:0] d1, input logic k1);
        exp_t       e;
        logic [7:0] key0, key1;
        bit         s0, s1, blk, bad;
        int         nptr;
        s0   = k0 && (d0 == 8'h1C);
        s1   = k1 && (d1 == 8'h1C);
        blk  = s0 || s1 || (k0 && d0 == 8'hBC) || (k1 && d1 == 8'hBC);
        key0 = ks[ptr];
        if (s0) begin
            key1 = ks[0];
            nptr = 1;
        end else begin
            key1 = ks[(ptr + 1) % KS_LEN];
            nptr = (ptr + 2) % KS_LEN;
        end
        if (s1) nptr = 0;
        ptr = nptr;
        e.data[7:0]  = k0 ? (s0 ? 8'hBC : d0) : (d0 ^ key0);
        e.data[15:8] = k1 ? (s1 ? 8'hBC : d1) : (d1 ^ key1);
        e.isk  = {k1, k0};
        e.lock = m_lock;
        e.err  = 1'b0;
        if (blk) begin
            if (!m_lock) begin
                if (s0 || s1) begin
                    m_lock = 1'b1;
                    m_miss = 0;
                end
            end else begin
                bad = (s0 || s1) ? (m_slot != 0) : (m_slot == 0);
                if (bad) begin
                    e.err = 1'b1;
                    m_miss++;
                    if (m_miss == MISS_MAX) begin
                        m_lock = 1'b0;
                        m_miss = 0;
                    end
                end else if (s0 || s1) begin
                    m_miss = 0;
                end
            end
            m_slot = (s0 || s1) ? 1 : (m_slot + 1) % 512;
        end
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; applies one cycle of input and returns at
    // the next falling edge.
    task automatic drive(input logic [7:0] d0, input logic k0,
                         input logic [7:0] d1, input logic k1);
        indata = {d1, d0};
        inisk  = {k1, k0};
        model_step(d0, k0, d1, k1);
        @(negedge clk);
    endtask

    task automatic data_cycle();
        drive(8'($urandom), 1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic bs_cycle();
        if ($urandom_range(0, 1) == 0) drive(8'hBC, 1'b1, 8'($urandom), 1'b0);
        else                           drive(8'($urandom), 1'b0, 8'hBC, 1'b1);
    endtask

    task automatic bs_run(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bs_cycle();
            if (gaps && $urandom_range(0, 3) == 0) data_cycle();
        end
    endtask

    task automatic random_cycle();
        int r;
        r = $urandom_range(0, 99);
        if (r < 1)       drive(8'h1C, 1'b1, 8'h1C, 1'b1);
        else if (r < 2)  drive(8'h1C, 1'b1, 8'($urandom), $urandom_range(0, 1) == 1);
        else if (r < 3)  drive(8'($urandom), 1'b0, 8'h1C, 1'b1);
        else if (r < 20) bs_cycle();
        else if (r < 24) drive(8'h3C, 1'b1, 8'($urandom), 1'b0);
        else             data_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_outdata"}, outdata, 16'h0000);
        chk({tag, "_outisk"}, {14'h0, outisk}, 16'h0000);
        chk({tag, "_locked"}, {15'h0, locked}, 16'h0000);
        chk({tag, "_err"}, {15'h0, err}, 16'h0000);
    endtask

    // Monitor: every clock after reset the DUT presents one output word.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rstn && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("outdata", outdata, mon_e.data);
                chk("outisk", {14'h0, outisk}, {14'h0, mon_e.isk});
                chk("err", {15'h0, err}, {15'h0, mon_e.err});
                chk("locked", {15'h0, locked}, {15'h0, mon_e.lock});
            end
        end
    end

    initial begin
        int guard;
        indata = 16'h0000;
        inisk  = 2'b00;
        rstn   = 1'b1;
        #1 rstn = 1'b0;
        build_keystream();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // SR in byte 0, then data equal to the keystream -> zeros
        rstn = 1'b1;
        drive(8'h1C, 1'b1, 8'hFF, 1'b0);
        drive(8'h17, 1'b0, 8'hC0, 1'b0);
        drive(8'h14, 1'b0, 8'hB2, 1'b0);

        // SR in byte 1 (early while locked), keystream restarts next cycle
        drive(8'h55, 1'b0, 8'h1C, 1'b1);
        drive(8'hFF, 1'b0, 8'h17, 1'b0);
        data_cycle();

        // Full 512-slot period, correctly placed SR
        bs_run(511, 1'b1);
        drive(8'($urandom), 1'b0, 8'h1C, 1'b1);
        drive(8'hFF, 1'b0, 8'h17, 1'b0);

        // Two missing SRs in a row drop lock
        bs_run(511, 1'b0);
        bs_cycle();
        bs_run(511, 1'b0);
        bs_cycle();
        repeat (3) data_cycle();

        // Relock, then an SR at slot 100
        drive(8'($urandom), 1'b0, 8'h1C, 1'b1);
        data_cycle();
        bs_run(99, 1'b1);
        drive(8'($urandom), 1'b0, 8'h1C, 1'b1);
        drive(8'hFF, 1'b0, 8'h17, 1'b0);
        repeat (2) data_cycle();

        // Random traffic
        for (int i = 0; i < 1500; i++) random_cycle();

        // Mid-stream reset while locked
        drive(8'h1C, 1'b1, 8'($urandom), 1'b0);
        repeat (3) data_cycle();
        bs_run(5, 1'b0);
        #1 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        rstn = 1'b1;
        repeat (4) data_cycle();
        bs_run(3, 1'b0);
        drive(8'h1C, 1'b1, 8'h1C, 1'b1);
        drive(8'hFF, 1'b0, 8'h17, 1'b0);
        repeat (4) data_cycle();
        bs_run(10, 1'b1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
